// File: rtl/glitch_pulse_gen_if.sv
// glitch_pulse_gen_if: trigger, control, config and status bundle for the glitch pulse generator
interface glitch_pulse_gen_if #(
  parameter int CNT_W = 16,
  parameter int REP_W = 8
);
  logic             trigger_i;
  logic             arm_i;
  logic             abort_i;
  logic             cfg_edge_i;
  logic [CNT_W-1:0] cfg_delay_i;
  logic [CNT_W-1:0] cfg_width_i;
  logic [CNT_W-1:0] cfg_gap_i;
  logic [REP_W-1:0] cfg_repeat_i;
  logic             pulse_o;
  logic             pulse_en_o;
  logic             armed_o;
  logic             busy_o;
  logic             done_o;
  modport master (
    output trigger_i, arm_i, abort_i, cfg_edge_i, cfg_delay_i, cfg_width_i, cfg_gap_i, cfg_repeat_i,
    input  pulse_o, pulse_en_o, armed_o, busy_o, done_o
  );
  modport slave (
    input  trigger_i, arm_i, abort_i, cfg_edge_i, cfg_delay_i, cfg_width_i, cfg_gap_i, cfg_repeat_i,
    output pulse_o, pulse_en_o, armed_o, busy_o, done_o
  );
endinterface

// File: rtl/glitch_pulse_gen.sv
// glitch_pulse_gen: trigger-synchronised generator of delayed, repeated glitch pulses
module glitch_pulse_gen #(
  parameter int CNT_W       = 16,
  parameter int REP_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  glitch_pulse_gen_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, ARMED, DELAY, PULSE, GAP} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES:0] sync;
  logic raw_edge, edge_q, ld, done_n, pulse_q, done_q, c_edge;
  logic [CNT_W-1:0] c_delay, c_width, c_gap, cnt, cnt_n, w_m1, g_m1;
  logic [REP_W-1:0] c_rep, rem, rem_n, n_m1;
  // top bit of sync is the edge-detect flop trailing the last synchroniser stage
  assign raw_edge = c_edge ? (sync[SYNC_STAGES] & ~sync[SYNC_STAGES-1])
                           : (sync[SYNC_STAGES-1] & ~sync[SYNC_STAGES]);
  // zero-valued width/gap/repeat behave as one
  assign w_m1 = (c_width == '0) ? '0 : c_width - CNT_W'(1);
  assign g_m1 = (c_gap == '0) ? '0 : c_gap - CNT_W'(1);
  assign n_m1 = (c_rep == '0) ? '0 : c_rep - REP_W'(1);
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rem_n   = rem;
    ld      = 1'b0;
    done_n  = 1'b0;
    if (bus.abort_i) state_n = IDLE;
    else
      unique case (state)
        IDLE: if (bus.arm_i) begin
          ld      = 1'b1;
          state_n = ARMED;
        end
        ARMED: if (edge_q) begin
          rem_n   = n_m1;
          state_n = (c_delay == '0) ? PULSE : DELAY;
          cnt_n   = (c_delay == '0) ? w_m1 : c_delay - CNT_W'(1);
        end
        DELAY: begin
          state_n = (cnt == '0) ? PULSE : DELAY;
          cnt_n   = (cnt == '0) ? w_m1 : cnt - CNT_W'(1);
        end
        PULSE:
          if (cnt != '0) cnt_n = cnt - CNT_W'(1);
          else if (rem == '0) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            rem_n   = rem - REP_W'(1);
            cnt_n   = g_m1;
            state_n = GAP;
          end
        GAP: begin
          state_n = (cnt == '0) ? PULSE : GAP;
          cnt_n   = (cnt == '0) ? w_m1 : cnt - CNT_W'(1);
        end
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      sync    <= '0;
      edge_q  <= 1'b0;
      cnt     <= '0;
      rem     <= '0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
      c_edge  <= 1'b0;
      c_delay <= '0;
      c_width <= '0;
      c_gap   <= '0;
      c_rep   <= '0;
    end else begin
      state   <= state_n;
      sync    <= {sync[SYNC_STAGES-1:0], bus.trigger_i};
      edge_q  <= (state == ARMED) && raw_edge;
      cnt     <= cnt_n;
      rem     <= rem_n;
      pulse_q <= (state_n == PULSE);
      done_q  <= done_n;
      if (ld) begin
        c_edge  <= bus.cfg_edge_i;
        c_delay <= bus.cfg_delay_i;
        c_width <= bus.cfg_width_i;
        c_gap   <= bus.cfg_gap_i;
        c_rep   <= bus.cfg_repeat_i;
      end
    end
  assign bus.pulse_o    = pulse_q;
  assign bus.done_o     = done_q;
  assign bus.armed_o    = (state == ARMED);
  assign bus.busy_o     = (state != IDLE);
  assign bus.pulse_en_o = (state == DELAY) || (state == PULSE) || (state == GAP);
endmodule

// File: tb/tb_glitch_pulse_gen.sv
// tb_glitch_pulse_gen: randomized and directed checks of glitch_pulse_gen against a timeline model
module tb_glitch_pulse_gen;
  localparam int CW = 6, RW = 3, S = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  glitch_pulse_gen_if #(.CNT_W(CW), .REP_W(RW)) bus ();
  glitch_pulse_gen #(.CNT_W(CW), .REP_W(RW), .SYNC_STAGES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction
  function automatic int done_cyc(input int d, input int w, input int g, input int n);
    return S + 1 + d + eff(n) * eff(w) + (eff(n) - 1) * eff(g);
  endfunction
  function automatic logic exp_pulse(input int k, input int d, input int w, input int g, input int n);
    int s;
    for (int p = 0; p < eff(n); p++) begin
      s = S + 1 + d + p * (eff(w) + eff(g));
      if (k >= s && k < s + eff(w)) return 1'b1;
    end
    return 1'b0;
  endfunction
  function automatic logic [4:0] outs();
    return {bus.pulse_o, bus.done_o, bus.busy_o, bus.armed_o, bus.pulse_en_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic rand_cfg();
    bus.cfg_edge_i   = 1'($urandom_range(0, 1));
    bus.cfg_delay_i  = CW'($urandom);
    bus.cfg_width_i  = CW'($urandom);
    bus.cfg_gap_i    = CW'($urandom);
    bus.cfg_repeat_i = RW'($urandom);
  endtask
  task automatic arm_cfg(input logic lvl, input logic e, input int d, input int w, input int g, input int n);
    bus.trigger_i = lvl;
    repeat (S + 2) tick();
    bus.cfg_edge_i   = e;
    bus.cfg_delay_i  = CW'(d);
    bus.cfg_width_i  = CW'(w);
    bus.cfg_gap_i    = CW'(g);
    bus.cfg_repeat_i = RW'(n);
    bus.arm_i = 1'b1;
    tick();
    bus.arm_i = 1'b0;
    checks++;
    if (outs() !== 5'b00110) begin
      errors++;
      $display("FAIL arm outs got=%b exp=00110 (pulse,done,busy,armed,en)", outs());
    end
  endtask
  task automatic fire(input logic e, input int d, input int w, input int g, input int n, input int abort_at, input bit noise);
    int dc, hz;
    bit ab;
    logic [4:0] ex;
    dc = done_cyc(d, w, g, n);
    hz = (abort_at >= 0) ? abort_at + 8 : dc + 4;
    bus.trigger_i = ~e;
    if (noise) rand_cfg();
    for (int k = 0; k <= hz; k++) begin
      tick();
      ab = (abort_at >= 0) && (k > abort_at);
      ex = ab ? 5'b0 : {exp_pulse(k, d, w, g, n), k == dc, k < dc, k <= S, k > S && k < dc};
      checks++;
      if (outs() !== ex) begin
        errors++;
        $display("FAIL seq d=%0d w=%0d g=%0d n=%0d cyc=%0d got=%b exp=%b", d, w, g, n, k, outs(), ex);
      end
      bus.abort_i = (k == abort_at);
      bus.arm_i   = 1'b0;
      if (noise && k >= 1 && k + 1 < dc) begin
        bus.trigger_i = 1'($urandom_range(0, 1));
        bus.arm_i     = ($urandom_range(0, 3) == 0);
        rand_cfg();
      end
    end
    bus.abort_i = 1'b0;
    bus.arm_i   = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (outs() !== 5'b0) begin
      errors++;
      $display("FAIL reset outs got=%b exp=00000", outs());
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (outs() !== 5'b0) begin
      errors++;
      $display("FAIL post_reset outs got=%b exp=00000", outs());
    end
  endtask
  task automatic test_basic();
    arm_cfg(1'b0, 1'b0, 5, 3, 0, 1);
    fire(1'b0, 5, 3, 0, 1, -1, 1'b0);
  endtask
  task automatic test_repeat();
    arm_cfg(1'b0, 1'b0, 0, 2, 4, 3);
    fire(1'b0, 0, 2, 4, 3, -1, 1'b0);
  endtask
  task automatic test_falling();
    arm_cfg(1'b0, 1'b1, 2, 2, 1, 2);
    bus.trigger_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (outs() !== 5'b00110) begin
        errors++;
        $display("FAIL rise_ignored cyc=%0d got=%b exp=00110", k, outs());
      end
    end
    fire(1'b1, 2, 2, 1, 2, -1, 1'b1);
  endtask
  task automatic test_abort();
    arm_cfg(1'b0, 1'b0, 1, 3, 2, 3);
    fire(1'b0, 1, 3, 2, 3, S + 1 + 1 + 3 + 2 + 1, 1'b0);
  endtask
  task automatic test_zero_cfg();
    arm_cfg(1'b0, 1'b0, 3, 0, 2, 0);
    fire(1'b0, 3, 0, 2, 0, -1, 1'b1);
  endtask
  task automatic test_max_cnt();
    arm_cfg(1'b0, 1'b0, 63, 63, 5, 2);
    fire(1'b0, 63, 63, 5, 2, -1, 1'b0);
  endtask
  task automatic test_random();
    logic e;
    int d, w, g, n;
    for (int i = 0; i < 12; i++) begin
      e = 1'($urandom_range(0, 1));
      d = $urandom_range(0, 7);
      w = $urandom_range(0, 5);
      g = $urandom_range(0, 5);
      n = $urandom_range(0, 4);
      arm_cfg(e, e, d, w, g, n);
      fire(e, d, w, g, n, -1, 1'b1);
    end
  endtask
  task automatic test_reset_mid();
    arm_cfg(1'b0, 1'b0, 0, 8, 1, 1);
    bus.trigger_i = 1'b1;
    repeat (S + 3) tick();
    checks++;
    if (bus.pulse_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_pulse pulse got=%b exp=1", bus.pulse_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 5'b0) begin
      errors++;
      $display("FAIL async_reset outs got=%b exp=00000", outs());
    end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k % 4 == 0) bus.trigger_i = ~bus.trigger_i;
      tick();
      checks++;
      if (outs() !== 5'b0) begin
        errors++;
        $display("FAIL no_rearm cyc=%0d got=%b exp=00000", k, outs());
      end
    end
  endtask

  initial begin
    bus.trigger_i = 1'b0;
    bus.arm_i = 1'b0;
    bus.abort_i = 1'b0;
    bus.cfg_edge_i = 1'b0;
    bus.cfg_delay_i = '0;
    bus.cfg_width_i = '0;
    bus.cfg_gap_i = '0;
    bus.cfg_repeat_i = '0;
    test_reset();
    test_basic();
    test_repeat();
    test_falling();
    test_abort();
    test_zero_cfg();
    test_max_cnt();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
